fft_radix2_seq: RTL and testbench
=================================

FFT_RADIX2_SEQ -- requirements
Module: fft_radix2_seq

Interface
REQ-001 Parameter LOG2N, default 3: transform size N = 2^LOG2N; legal range 2..10.
REQ-002 Parameter PIPE_LAT, default 2: butterfly datapath latency in cycles from issue to write-back; legal range 1..8.
REQ-003 Reset rst is synchronous and active-high; clock clk.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start_i  in  1  begin one transform; sampled only in IDLE.
REQ-007 alu_ready_i  in  1  datapath can accept a butterfly this cycle; low = issue stall.
REQ-008 bfly_valid_o  out  1  operand addresses, twiddle index and mode are valid this cycle.
REQ-009 rd_addr_a_o / rd_addr_b_o  out  LOG2N  upper/lower butterfly operand addresses.
REQ-010 tw_idx_o  out  LOG2N-1  twiddle-ROM index W_N^k.
REQ-011 wr_en_o  out  1  write-back strobe for the butterfly issued PIPE_LAT cycles earlier.
REQ-012 wr_addr_a_o / wr_addr_b_o  out  LOG2N  in-place write-back addresses.
REQ-013 stage_o  out  ceil(log2(LOG2N+1))  current stage index 0..LOG2N-1.
REQ-014 busy_o  out  1  high from leaving IDLE until the return to IDLE.
REQ-015 done_o  out  1  single-cycle completion pulse.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, DRAIN and DONE, with a stage counter s and a butterfly counter k (0..N/2-1).
REQ-017 IDLE: when start_i=1, the block SHALL clear s and k and go to ISSUE on the next edge; otherwise it remains in IDLE.
REQ-018 ISSUE with alu_ready_i=1: bfly_valid_o=1; span=2^s, pos=k mod span, rd_addr_a_o=(k>>s)*2*span+pos, rd_addr_b_o=rd_addr_a_o+span, tw_idx_o=pos<<(LOG2N-1-s); then k increments.
REQ-019 ISSUE with alu_ready_i=0: bfly_valid_o=0; s and k hold; the write-back pipeline still advances.
REQ-020 On issue of k=N/2-1, the FSM SHALL go to DRAIN with k cleared.
REQ-021 DRAIN SHALL last exactly PIPE_LAT cycles with no issue, so that every write of stage s lands before any read of stage s+1.
REQ-022 At the end of DRAIN: if s<LOG2N-1, s increments and the FSM goes to ISSUE; otherwise it goes to DONE.
REQ-023 DONE SHALL last one cycle with done_o=1 and busy_o=1, then go to IDLE; busy_o=0 in IDLE.
REQ-024 The write-back pipeline SHALL be a PIPE_LAT-deep shift register of {valid, addr_a, addr_b}; wr_en_o/wr_addr_*_o are its last stage; wr_en_o=1 exactly PIPE_LAT cycles after each cycle with bfly_valid_o=1.
REQ-025 The write-back pipeline SHALL not be stall-gated by alu_ready_i.
REQ-026 start_i asserted while busy_o=1 SHALL be ignored (not queued).
REQ-027 Without stalls, done_o SHALL be high in cycle LOG2N*(N/2+PIPE_LAT)+1 after the edge that samples start_i.
REQ-028 All address arithmetic is unsigned and modulo 2^LOG2N; no address may exceed N-1.

Reset
REQ-029 On rst=1 at an edge, the block SHALL enter IDLE, clear s, k and all pipeline valid bits, and drive all outputs to 0 on the following cycle, including mid-transform; in-flight write-backs are discarded.
REQ-030 After reset, the first start_i SHALL begin a full transform from stage 0.

Verification
REQ-031 LOG2N=3, PIPE_LAT=2, alu_ready_i=1, pulse start_i -> issues (a,b,tw) for stage 0: (0,1,0),(2,3,0),(4,5,0),(6,7,0); stage 1: (0,2,0),(1,3,2),(4,6,0),(5,7,2); stage 2: (0,4,0),(1,5,1),(2,6,2),(3,7,3); done_o in cycle 19.
REQ-032 Same configuration, hold alu_ready_i=0 for 3 cycles at stage-1 k=1 -> (1,3,2) is issued after the stall; stage-0 writes still complete; done_o in cycle 22.
REQ-033 Every issue -> wr_en_o with identical addresses exactly 2 cycles later; no stage-(s+1) read occurs in the cycle of, or before, the last stage-s write.
REQ-034 start_i re-asserted at cycle 5 -> ignored; exactly one done_o pulse; busy_o drops in cycle 20.
REQ-035 rst during stage-1 DRAIN -> all outputs 0 the next cycle, no wr_en_o thereafter; a new start_i produces the REQ-031 sequence.
REQ-036 LOG2N=4, PIPE_LAT=3 -> 4 stages x 8 butterflies; stage-3 k=7 gives (7,15,7); done_o in cycle 45.

Source files
------------

// File: rtl/fft_radix2_seq.sv
// In-place radix-2 FFT address sequencer: walks LOG2N stages of N/2 butterflies,
// issues operand/twiddle addresses and replays the addresses PIPE_LAT cycles later for write-back.
module fft_radix2_seq #(
   parameter int LOG2N    = 3,
   parameter int PIPE_LAT = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start_i,
   input  logic                             alu_ready_i,
   output logic                             bfly_valid_o,
   output logic [LOG2N-1:0]                 rd_addr_a_o,
   output logic [LOG2N-1:0]                 rd_addr_b_o,
   output logic [LOG2N-2:0]                 tw_idx_o,
   output logic                             wr_en_o,
   output logic [LOG2N-1:0]                 wr_addr_a_o,
   output logic [LOG2N-1:0]                 wr_addr_b_o,
   output logic [$clog2(LOG2N+1)-1:0]       stage_o,
   output logic                             busy_o,
   output logic                             done_o
);
   localparam int SW = $clog2(LOG2N + 1);
   localparam int DW = $clog2(PIPE_LAT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   typedef struct packed {
      logic             vld;
      logic [LOG2N-1:0] a;
      logic [LOG2N-1:0] b;
   } wb_t;

   state_t               state;
   logic [SW-1:0]        s;
   logic [LOG2N-2:0]     k;
   logic [DW-1:0]        dcnt;
   wb_t [PIPE_LAT-1:0]   wb_pipe;

   logic                 issue;
   logic [LOG2N-2:0]     mask, pos, hi, tw;
   logic [LOG2N-1:0]     span, addr_a, addr_b;
   logic [SW-1:0]        tw_sh;

   // pos = k mod span, hi = (k / span) * span; doubling hi skips the partner half-block
   always_comb begin
      mask   = ~({(LOG2N-1){1'b1}} << s);
      pos    = k & mask;
      hi     = k & ~mask;
      span   = {{(LOG2N-1){1'b0}}, 1'b1} << s;
      addr_a = {hi, 1'b0} | {1'b0, pos};
      addr_b = addr_a + span;
      tw_sh  = SW'(LOG2N - 1) - s;
      tw     = pos << tw_sh;
   end

   assign issue        = (state == ISSUE) && alu_ready_i;
   assign bfly_valid_o = issue;
   assign rd_addr_a_o  = issue ? addr_a : '0;
   assign rd_addr_b_o  = issue ? addr_b : '0;
   assign tw_idx_o     = issue ? tw : '0;
   assign wr_en_o      = wb_pipe[PIPE_LAT-1].vld;
   assign wr_addr_a_o  = wb_pipe[PIPE_LAT-1].a;
   assign wr_addr_b_o  = wb_pipe[PIPE_LAT-1].b;
   assign stage_o      = s;
   assign busy_o       = (state != IDLE);
   assign done_o       = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         s       <= '0;
         k       <= '0;
         dcnt    <= '0;
         wb_pipe <= '0;
      end else begin
         // write-back shift runs every cycle, independent of issue stalls
         for (int i = PIPE_LAT - 1; i > 0; i--)
            wb_pipe[i] <= wb_pipe[i-1];
         wb_pipe[0] <= issue ? '{vld: 1'b1, a: addr_a, b: addr_b} : '0;

         case (state)
            IDLE: begin
               if (start_i) begin
                  s     <= '0;
                  k     <= '0;
                  dcnt  <= '0;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (alu_ready_i) begin
                  if (k == '1) begin
                     k     <= '0;
                     dcnt  <= '0;
                     state <= DRAIN;
                  end else begin
                     k <= k + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (dcnt == DW'(PIPE_LAT - 1)) begin
                  dcnt <= '0;
                  if (s == SW'(LOG2N - 1)) begin
                     state <= DONE;
                  end else begin
                     s     <= s + 1'b1;
                     state <= ISSUE;
                  end
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            DONE: begin
               s     <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft_radix2_seq.sv
// Bench for fft_radix2_seq: two configurations (3/2 and 4/3) checked every cycle against
// a schedule model built from group/offset loops, plus literal issue/done-cycle pins.
module tb_fft_radix2_seq;
   logic       clk = 1'b0;
   logic [1:0] rst_v, start_v, rdy_v;

   logic       v0, we0, busy0, done0;
   logic [2:0] ra0, rb0, wa0, wb0;
   logic [1:0] tw0, st0;
   logic       v1, we1, busy1, done1;
   logic [3:0] ra1, rb1, wa1, wb1;
   logic [2:0] tw1, st1;

   always #5 clk = ~clk;

   fft_radix2_seq #(.LOG2N(3), .PIPE_LAT(2)) dut0 (
      .clk(clk), .rst(rst_v[0]), .start_i(start_v[0]), .alu_ready_i(rdy_v[0]),
      .bfly_valid_o(v0), .rd_addr_a_o(ra0), .rd_addr_b_o(rb0), .tw_idx_o(tw0),
      .wr_en_o(we0), .wr_addr_a_o(wa0), .wr_addr_b_o(wb0), .stage_o(st0),
      .busy_o(busy0), .done_o(done0));

   fft_radix2_seq #(.LOG2N(4), .PIPE_LAT(3)) dut1 (
      .clk(clk), .rst(rst_v[1]), .start_i(start_v[1]), .alu_ready_i(rdy_v[1]),
      .bfly_valid_o(v1), .rd_addr_a_o(ra1), .rd_addr_b_o(rb1), .tw_idx_o(tw1),
      .wr_en_o(we1), .wr_addr_a_o(wa1), .wr_addr_b_o(wb1), .stage_o(st1),
      .busy_o(busy1), .done_o(done1));

   // schedule slot: 0 = butterfly (waits for ready), 1 = drain gap, 2 = done
   typedef struct {int kind; int stg; int a; int b; int tw;} slot_t;

   slot_t sl [2][64];
   int    sh [2] = '{0, 0};
   int    st [2] = '{0, 0};
   int    wc [2][64];
   int    wqa[2][64];
   int    wqb[2][64];
   int    wh [2] = '{0, 0};
   int    wt [2] = '{0, 0};
   int    start_cyc[2];
   int    nissue[2];
   int    exp_done[2] = '{0, 0};
   bit    tbl_en[2] = '{0, 0};
   int    cyc = 0;
   int    cmp_n = 0;
   int    err_n = 0;

   int tbl_a[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
   int tbl_b[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
   int tbl_t[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

   task automatic chk(string name, int g, int act, int exp);
      cmp_n++;
      if (act != exp) begin
         err_n++;
         $display("FAIL %s[inst%0d] cycle %0d: got %0d expected %0d", name, g, cyc, act, exp);
      end
   endtask

   task automatic build(int g, int lg, int pl);
      int n = 1 << lg;
      st[g] = 0;
      sh[g] = 0;
      for (int s = 0; s < lg; s++) begin
         int span = 1 << s;
         for (int grp = 0; grp < n; grp += 2 * span)
            for (int j = 0; j < span; j++) begin
               sl[g][st[g]] = '{0, s, grp + j, grp + j + span, j * (n / (2 * span))};
               st[g]++;
            end
         for (int d = 0; d < pl; d++) begin
            sl[g][st[g]] = '{1, s, 0, 0, 0};
            st[g]++;
         end
      end
      sl[g][st[g]] = '{2, lg - 1, 0, 0, 0};
      st[g]++;
   endtask

   task automatic step(int g, int lg, int pl, int rst, int start, int rdy,
                       int v, int ra, int rb, int tw, int we, int wa, int wb,
                       int stg, int busy, int done);
      int ev = 0, ea = 0, eb = 0, et = 0, ewe = 0, ewa = 0, ewb = 0;
      int es = 0, ebusy = 0, edone = 0;
      slot_t f;
      f = '{1, 0, 0, 0, 0};
      if (sh[g] != st[g]) begin
         f     = sl[g][sh[g]];
         ebusy = 1;
         es    = f.stg;
         if (f.kind == 0 && rdy != 0) begin
            ev = 1; ea = f.a; eb = f.b; et = f.tw;
         end
         if (f.kind == 2) edone = 1;
      end
      if (wh[g] != wt[g] && wc[g][wh[g] % 64] == cyc - pl) begin
         ewe = 1;
         ewa = wqa[g][wh[g] % 64];
         ewb = wqb[g][wh[g] % 64];
      end
      chk("bfly_valid", g, v, ev);
      chk("rd_addr_a", g, ra, ea);
      chk("rd_addr_b", g, rb, eb);
      chk("tw_idx", g, tw, et);
      chk("wr_en", g, we, ewe);
      chk("wr_addr_a", g, wa, ewa);
      chk("wr_addr_b", g, wb, ewb);
      chk("stage", g, stg, es);
      chk("busy", g, busy, ebusy);
      chk("done", g, done, edone);

      if (ewe != 0) wh[g]++;
      if (rst != 0) begin
         sh[g] = 0; st[g] = 0; wh[g] = 0; wt[g] = 0;
      end else if (sh[g] == st[g]) begin
         if (start != 0) begin
            build(g, lg, pl);
            start_cyc[g] = cyc;
            nissue[g]    = 0;
         end
      end else if (f.kind == 0) begin
         if (rdy != 0) begin
            wc [g][wt[g] % 64] = cyc;
            wqa[g][wt[g] % 64] = f.a;
            wqb[g][wt[g] % 64] = f.b;
            wt[g]++;
            if (g == 0 && tbl_en[0] && nissue[0] < 12) begin
               chk("tbl_a", g, f.a, tbl_a[nissue[0]]);
               chk("tbl_b", g, f.b, tbl_b[nissue[0]]);
               chk("tbl_tw", g, f.tw, tbl_t[nissue[0]]);
            end
            if (g == 1 && nissue[1] == 31) begin
               chk("last_a", g, f.a, 7);
               chk("last_b", g, f.b, 15);
               chk("last_tw", g, f.tw, 7);
            end
            nissue[g]++;
            sh[g]++;
         end
      end else begin
         if (f.kind == 2 && exp_done[g] > 0)
            chk("done_cycle", g, cyc - start_cyc[g], exp_done[g]);
         sh[g]++;
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      step(0, 3, 2, int'(rst_v[0]), int'(start_v[0]), int'(rdy_v[0]),
           int'(v0), int'(ra0), int'(rb0), int'(tw0), int'(we0), int'(wa0), int'(wb0),
           int'(st0), int'(busy0), int'(done0));
      step(1, 4, 3, int'(rst_v[1]), int'(start_v[1]), int'(rdy_v[1]),
           int'(v1), int'(ra1), int'(rb1), int'(tw1), int'(we1), int'(wa1), int'(wb1),
           int'(st1), int'(busy1), int'(done1));
   end

   task automatic adv(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(int g);
      start_v[g] = 1'b1;
      adv(1);
      start_v[g] = 1'b0;
   endtask

   initial begin
      rst_v   = 2'b11;
      start_v = 2'b00;
      rdy_v   = 2'b11;
      adv(3);
      rst_v = 2'b00;
      adv(2);

      // plain transform: fixed issue order, done in cycle 19
      exp_done[0] = 19;
      tbl_en[0]   = 1'b1;
      pulse(0);
      adv(25);

      // three stall cycles at stage-1 k=1 push done to cycle 22
      exp_done[0] = 22;
      pulse(0);
      adv(7);
      rdy_v[0] = 1'b0;
      adv(3);
      rdy_v[0] = 1'b1;
      adv(25);

      // start re-asserted mid-transform must be ignored
      exp_done[0] = 19;
      pulse(0);
      adv(4);
      start_v[0] = 1'b1;
      adv(1);
      start_v[0] = 1'b0;
      adv(25);

      // reset in the first stage-1 drain cycle, then a fresh transform
      exp_done[0] = 0;
      pulse(0);
      adv(10);
      rst_v[0] = 1'b1;
      adv(1);
      rst_v[0] = 1'b0;
      adv(6);
      exp_done[0] = 19;
      pulse(0);
      adv(25);

      // 16-point configuration with three-cycle datapath
      exp_done[1] = 45;
      pulse(1);
      adv(55);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end

endmodule
